// File: rtl/icache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package icache_pkg;

  // Default geometry; the cache modules take these as parameter defaults.
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned DEF_SETS       = 16;

  // Address field widths for the default geometry.
  localparam int unsigned WORD_BITS  = $clog2(DEF_LINE_WORDS);
  localparam int unsigned INDEX_BITS = $clog2(DEF_SETS);
  localparam int unsigned TAG_BITS   = DEF_ADDR_W - 2 - WORD_BITS - INDEX_BITS;

  // Controller state encoding.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_LOOKUP   = 3'd1;
  localparam state_t S_MISS_REQ = 3'd2;
  localparam state_t S_REFILL   = 3'd3;
  localparam state_t S_RESP     = 3'd4;

  // Refill beat counter for the default line size.
  typedef logic [WORD_BITS-1:0] beat_t;

endpackage

// File: rtl/icache_dm_array.sv
// Tag, data and valid storage for the direct-mapped instruction cache.
module icache_dm_array
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned SETS       = DEF_SETS,
  parameter int unsigned TAG_W      = TAG_BITS
) (
  input  logic                          clk,
  input  logic                          rst_i,
  input  logic [$clog2(SETS)-1:0]       rd_index_i,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word_i,
  output logic [31:0]                   rd_data_o,
  output logic [TAG_W-1:0]              rd_tag_o,
  output logic                          rd_valid_o,
  input  logic                          wr_en_i,
  input  logic [$clog2(SETS)-1:0]       wr_index_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_beat_i,
  input  logic [31:0]                   wr_data_i,
  input  logic                          tag_write_i,
  input  logic [TAG_W-1:0]              wr_tag_i,
  input  logic                          wr_valid_i,
  input  logic                          flush_all_i
);

  localparam int unsigned DEPTH = SETS * LINE_WORDS;

  logic [31:0]      data_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [SETS-1:0]  valid_q;

  // Data words are written one refill beat at a time; no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[{wr_index_i, wr_beat_i}] <= wr_data_i;
    end
  end

  // Tag is written together with the final refill beat.
  always_ff @(posedge clk) begin
    if (tag_write_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
  end

  // Valid bits: cleared by reset or flush, set when a line completes.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (flush_all_i) begin
      valid_q <= '0;
    end else if (tag_write_i) begin
      valid_q[wr_index_i] <= wr_valid_i;
    end
  end

  assign rd_data_o  = data_q[{rd_index_i, rd_word_i}];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with burst line refill.
module icache_dm
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned SETS       = DEF_SETS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              request_i,
  input  logic [ADDR_W-1:0] instAddr_i,
  output logic [31:0]       inst_o,
  output logic              dataOk_o,
  input  logic              flush_i,
  output logic              memReq_o,
  output logic [ADDR_W-1:0] memAddr_o,
  input  logic              memGrant_i,
  input  logic              memValid_i,
  input  logic [31:0]       memData_i
);

  localparam int unsigned WB = $clog2(LINE_WORDS);
  localparam int unsigned IB = $clog2(SETS);
  localparam int unsigned TB = ADDR_W - 2 - WB - IB;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_WORDS * 4 - 1));
  localparam logic [WB-1:0]     LAST_BEAT = WB'(LINE_WORDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [WB-1:0]     beat_q, beat_d;
  logic              flush_pend_q, flush_pend_d;
  logic              hit_q, hit_d;
  logic              data_ok_q, data_ok_d;
  logic [31:0]       inst_q, inst_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [ADDR_W-1:0] rd_addr_c;
  logic [IB-1:0]     rd_index_c;
  logic [WB-1:0]     rd_word_c;
  logic [31:0]       rd_data_c;
  logic [TB-1:0]     rd_tag_c;
  logic              rd_valid_c;
  logic              hit_c;
  logic              wr_en_c;
  logic              tag_write_c;
  logic              flush_all_c;
  logic              unused_c;

  // In IDLE the lookup uses the incoming address so a hit answers next cycle.
  assign rd_addr_c  = (state_q == S_IDLE) ? instAddr_i : req_addr_q;
  assign rd_index_c = rd_addr_c[2 + WB +: IB];
  assign rd_word_c  = rd_addr_c[2 +: WB];
  assign hit_c      = rd_valid_c && (rd_tag_c == rd_addr_c[ADDR_W-1 -: TB]);
  assign unused_c   = &{1'b0, rd_addr_c[1:0]};

  assign wr_en_c     = (state_q == S_REFILL) && memValid_i;
  assign tag_write_c = wr_en_c && (beat_q == LAST_BEAT);

  icache_dm_array #(
    .LINE_WORDS(LINE_WORDS),
    .SETS      (SETS),
    .TAG_W     (TB)
  ) u_array (
    .clk        (clk),
    .rst_i      (reset_n),
    .rd_index_i (rd_index_c),
    .rd_word_i  (rd_word_c),
    .rd_data_o  (rd_data_c),
    .rd_tag_o   (rd_tag_c),
    .rd_valid_o (rd_valid_c),
    .wr_en_i    (wr_en_c),
    .wr_index_i (req_addr_q[2 + WB +: IB]),
    .wr_beat_i  (beat_q),
    .wr_data_i  (memData_i),
    .tag_write_i(tag_write_c),
    .wr_tag_i   (req_addr_q[ADDR_W-1 -: TB]),
    .wr_valid_i (!(flush_pend_q || flush_i)),
    .flush_all_i(flush_all_c)
  );

  // Next-state and registered-output logic for the fetch/refill controller.
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    beat_d       = beat_q;
    flush_pend_d = flush_pend_q || flush_i;
    hit_d        = hit_q;
    data_ok_d    = 1'b0;
    inst_d       = inst_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    flush_all_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        flush_pend_d = 1'b0;
        if (flush_i) begin
          flush_all_c = 1'b1;
        end else if (request_i) begin
          req_addr_d = instAddr_i;
          hit_d      = hit_c;
          data_ok_d  = hit_c;
          if (hit_c) begin
            inst_d = rd_data_c;
          end
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_q) begin
          state_d = S_IDLE;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = req_addr_q & LINE_MASK;
          state_d    = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (memGrant_i) begin
          mem_req_d = 1'b0;
          beat_d    = '0;
          state_d   = S_REFILL;
        end
      end
      S_REFILL: begin
        if (memValid_i) begin
          beat_d = beat_q + WB'(1);
          if (beat_q == LAST_BEAT) begin
            data_ok_d = 1'b1;
            inst_d    = (rd_word_c == beat_q) ? memData_i : rd_data_c;
            state_d   = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush seen while busy invalidates everything on the way back to IDLE.
    if ((state_q != S_IDLE) && (state_d == S_IDLE) && flush_pend_d) begin
      flush_all_c  = 1'b1;
      flush_pend_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q      <= S_IDLE;
      req_addr_q   <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      hit_q        <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
      hit_q        <= hit_d;
      data_ok_q    <= data_ok_d;
      inst_q       <= inst_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign dataOk_o  = data_ok_q;
  assign inst_o    = inst_q;
  assign memReq_o  = mem_req_q;
  assign memAddr_o = mem_addr_q;

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm against a line-level cache model.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        request_i;
  logic [31:0] instAddr_i;
  logic [31:0] inst_o;
  logic        dataOk_o;
  logic        flush_i;
  logic        memReq_o;
  logic [31:0] memAddr_o;
  logic        memGrant_i;
  logic        memValid_i;
  logic [31:0] memData_i;

  int total = 0;
  int bad   = 0;

  // Reference model: per-set valid, tag and line contents.
  logic        mvalid [16];
  logic [23:0] mtag   [16];
  logic [31:0] mdata  [16][4];

  icache_dm dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .request_i (request_i),
    .instAddr_i(instAddr_i),
    .inst_o    (inst_o),
    .dataOk_o  (dataOk_o),
    .flush_i   (flush_i),
    .memReq_o  (memReq_o),
    .memAddr_o (memAddr_o),
    .memGrant_i(memGrant_i),
    .memValid_i(memValid_i),
    .memData_i (memData_i)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int s = 0; s < 16; s++) mvalid[s] = 1'b0;
  endtask

  // One fetch: predicts hit/miss from the model, plays memory, checks timing and data.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] beats [4],
                       input int gdly, input logic [15:0] vpat, input int flush_cyc,
                       input bit flush_req, input string nm);
    int          idx, w, nb, cyc;
    logic [23:0] tg;
    bit          hit, flushed, v;
    logic [31:0] expv;
    idx = int'(addr[7:4]);
    w   = int'(addr[3:2]);
    tg  = addr[31:8];
    if (flush_req) model_clear();
    hit  = mvalid[idx] && (mtag[idx] == tg);
    expv = hit ? mdata[idx][w] : beats[w];
    flushed = 1'b0;

    @(negedge clk);
    request_i  = 1'b1;
    instAddr_i = addr;
    flush_i    = flush_req;
    if (flush_req) begin
      @(negedge clk);
      flush_i = 1'b0;
      total++;
      if (dataOk_o !== 1'b0) begin
        bad++; $display("FAIL %s flush_prio dataOk got=%0b exp=0", nm, dataOk_o);
      end
    end
    @(negedge clk);
    if (hit) begin
      total++;
      if (dataOk_o !== 1'b1 || inst_o !== expv || memReq_o !== 1'b0) begin
        bad++; $display("FAIL %s hit ok=%0b inst=%h memReq=%0b exp ok=1 inst=%h memReq=0",
                        nm, dataOk_o, inst_o, memReq_o, expv);
      end
      request_i = 1'b0;
    end else begin
      total++;
      if (dataOk_o !== 1'b0) begin
        bad++; $display("FAIL %s miss_lookup dataOk got=%0b exp=0", nm, dataOk_o);
      end
      @(negedge clk);
      total++;
      if (memReq_o !== 1'b1 || memAddr_o !== (addr & 32'hFFFF_FFF0)) begin
        bad++; $display("FAIL %s miss_req req=%0b addr=%h exp req=1 addr=%h",
                        nm, memReq_o, memAddr_o, addr & 32'hFFFF_FFF0);
      end
      repeat (gdly) @(negedge clk);
      total++;
      if (memReq_o !== 1'b1) begin
        bad++; $display("FAIL %s req_hold got=%0b exp=1", nm, memReq_o);
      end
      memGrant_i = 1'b1;
      @(negedge clk);
      memGrant_i = 1'b0;
      total++;
      if (memReq_o !== 1'b0) begin
        bad++; $display("FAIL %s req_drop got=%0b exp=0", nm, memReq_o);
      end
      nb  = 0;
      cyc = 0;
      while (nb < 4 && cyc < 64) begin
        v = (cyc < 16) ? vpat[cyc] : 1'b1;
        memValid_i = v;
        memData_i  = v ? beats[nb] : $urandom;
        flush_i    = (cyc == flush_cyc);
        if (cyc == flush_cyc) flushed = 1'b1;
        if (v) nb++;
        cyc++;
        @(negedge clk);
        memValid_i = 1'b0;
        flush_i    = 1'b0;
        if (nb < 4) begin
          total++;
          if (dataOk_o !== 1'b0) begin
            bad++; $display("FAIL %s early_ok beat=%0d got=%0b exp=0", nm, nb, dataOk_o);
          end
        end
      end
      total++;
      if (dataOk_o !== 1'b1 || inst_o !== expv) begin
        bad++; $display("FAIL %s resp ok=%0b inst=%h exp ok=1 inst=%h", nm, dataOk_o, inst_o, expv);
      end
      request_i = 1'b0;
      for (int k = 0; k < 4; k++) mdata[idx][k] = beats[k];
      mtag[idx]   = tg;
      mvalid[idx] = 1'b1;
      if (flushed) model_clear();
    end
    @(negedge clk);
    total++;
    if (dataOk_o !== 1'b0) begin
      bad++; $display("FAIL %s ok_twice got=%0b exp=0", nm, dataOk_o);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (dataOk_o !== 1'b0 || memReq_o !== 1'b0 || memAddr_o !== 32'h0 || inst_o !== 32'h0) begin
      bad++; $display("FAIL reset ok=%0b req=%0b addr=%h inst=%h exp all 0",
                      dataOk_o, memReq_o, memAddr_o, inst_o);
    end
    reset_n = 1'b0;
    model_clear();
  endtask

  task automatic test_cold_miss_and_hit();
    logic [31:0] b [4];
    b = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    fetch(32'h0000_0010, b, 1, 16'hFFFF, -1, 1'b0, "cold_miss");
    fetch(32'h0000_0018, b, 0, 16'hFFFF, -1, 1'b0, "hit_after_refill");
    total++;
    if (!(mvalid[1] && mdata[1][2] == 32'hA2)) begin
      bad++; $display("FAIL model_hit_state valid=%0b data=%h exp valid=1 data=a2", mvalid[1], mdata[1][2]);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] b [4];
    b = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    fetch(32'h0000_0110, b, 0, 16'hFFFF, -1, 1'b0, "conflict_fill");
    b = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    fetch(32'h0000_0010, b, 2, 16'hFFFF, -1, 1'b0, "conflict_refetch");
  endtask

  task automatic test_gaps();
    logic [31:0] b [4];
    b = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    fetch(32'h0000_020C, b, 0, 16'b1111_1111_1101_1001, -1, 1'b0, "gaps");
    fetch(32'h0000_0204, b, 0, 16'hFFFF, -1, 1'b0, "gaps_hit");
  endtask

  task automatic test_flush();
    logic [31:0] b [4];
    b = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
    fetch(32'h0000_0300, b, 0, 16'hFFFF, -1, 1'b0, "flush_prefill");
    b = '{32'hF0, 32'hF1, 32'hF2, 32'hF3};
    fetch(32'h0000_0404, b, 1, 16'hFFFF, 1, 1'b0, "flush_refill");
    fetch(32'h0000_0404, b, 0, 16'hFFFF, -1, 1'b0, "flush_same_miss");
    b = '{32'hE4, 32'hE5, 32'hE6, 32'hE7};
    fetch(32'h0000_0300, b, 0, 16'hFFFF, -1, 1'b0, "flush_other_miss");
    fetch(32'h0000_0308, b, 0, 16'hFFFF, -1, 1'b1, "flush_with_req");
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] b [4];
    @(negedge clk);
    request_i  = 1'b1;
    instAddr_i = 32'h0000_0010;
    repeat (2) @(negedge clk);
    memGrant_i = 1'b1;
    @(negedge clk);
    memGrant_i = 1'b0;
    request_i  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      memValid_i = 1'b1;
      memData_i  = 32'h7700 + 32'(k);
      @(negedge clk);
    end
    memValid_i = 1'b0;
    reset_n    = 1'b1;
    @(negedge clk);
    total++;
    if (memReq_o !== 1'b0 || dataOk_o !== 1'b0) begin
      bad++; $display("FAIL reset_mid req=%0b ok=%0b exp 0 0", memReq_o, dataOk_o);
    end
    reset_n = 1'b0;
    model_clear();
    b = '{32'h1234_0000, 32'h1234_0001, 32'h1234_0002, 32'h1234_0003};
    fetch(32'h0000_0010, b, 0, 16'hFFFF, -1, 1'b0, "after_reset_miss");
  endtask

  task automatic test_random();
    logic [31:0] b [4];
    logic [31:0] a;
    int          fc;
    for (int n = 0; n < 200; n++) begin
      a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 15)) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      for (int k = 0; k < 4; k++) b[k] = $urandom;
      fc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
      fetch(a, b, int'($urandom_range(0, 3)), 16'($urandom), fc,
            ($urandom_range(0, 19) == 0), "random");
    end
  endtask

  initial begin
    reset_n    = 1'b1;
    request_i  = 1'b0;
    instAddr_i = '0;
    flush_i    = 1'b0;
    memGrant_i = 1'b0;
    memValid_i = 1'b0;
    memData_i  = '0;
    test_reset();
    test_cold_miss_and_hit();
    test_conflict();
    test_gaps();
    test_flush();
    test_reset_mid_refill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
